// File: rtl/pll_reset_ctrl_if.sv
// Signal bundle between the PLL reset supervisor and its PLL / downstream consumers.
// The master side is the supervisor; the slave side is the PLL plus the reset consumers.
`timescale 1ns/1ps
interface pll_reset_ctrl_if;
   logic       pll_locked;
   logic       relock_req;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [2:0] retry_count;
   logic [7:0] relock_events;

   modport master (
      input  pll_locked,
      input  relock_req,
      output pll_rst,
      output sys_rst,
      output ready,
      output fail,
      output retry_count,
      output relock_events
   );

   modport slave (
      output pll_locked,
      output relock_req,
      input  pll_rst,
      input  sys_rst,
      input  ready,
      input  fail,
      input  retry_count,
      input  relock_events
   );
endinterface

// File: rtl/pll_reset_ctrl.sv
// PLL reset supervisor: pulses the PLL reset, waits for a stable lock, then releases sys_rst.
// Bounded retries on lock timeout end in a sticky fail state; lock losses in RUN are counted.
`timescale 1ns/1ps
module pll_reset_ctrl #(
   parameter int RST_PULSE_CYCLES   = 16,
   parameter int LOCK_TIMEOUT       = 50000,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES        = 7,
   parameter int CNT_W              = 16
) (
   input logic             refclk,
   input logic             rst,
   pll_reset_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAIL_ST
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [2:0]       RETRY_MAX   = 3'(MAX_RETRIES);

   state_t           state, next_state;
   logic [CNT_W-1:0] cnt, next_cnt;
   logic [2:0]       retry_q, next_retry;
   logic [7:0]       events_q, next_events;
   logic             sync1, lk_s;
   logic             pll_rst_q, sys_rst_q, ready_q, fail_q;

   // pll_locked comes from the PLL's own timing domain, so two flops before use
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         lk_s  <= 1'b0;
      end else begin
         sync1 <= bus.pll_locked;
         lk_s  <= sync1;
      end
   end

   always_comb begin
      next_state  = state;
      next_cnt    = cnt;
      next_retry  = retry_q;
      next_events = events_q;
      case (state)
         RESET_PLL: begin
            if (cnt == RST_LAST) begin
               next_state = WAIT_LOCK;
               next_cnt   = '0;
            end else begin
               next_cnt = cnt + CNT_W'(1);
            end
         end
         WAIT_LOCK: begin
            if (lk_s) begin
               next_state = STABLE;
               next_cnt   = '0;
            end else if (cnt == TIMEOUT_LAST) begin
               next_cnt = '0;
               if (retry_q == RETRY_MAX) begin
                  next_state = FAIL_ST;
               end else begin
                  next_state = RESET_PLL;
                  next_retry = retry_q + 3'd1;
               end
            end else begin
               next_cnt = cnt + CNT_W'(1);
            end
         end
         STABLE: begin
            // A dropout here is treated as a glitch: back to waiting without spending a retry
            if (!lk_s) begin
               next_state = WAIT_LOCK;
               next_cnt   = '0;
            end else if (cnt == STABLE_LAST) begin
               next_state = RUN;
               next_cnt   = '0;
               next_retry = '0;
            end else begin
               next_cnt = cnt + CNT_W'(1);
            end
         end
         RUN: begin
            next_retry = '0;
            if (!lk_s) begin
               next_state  = RESET_PLL;
               next_cnt    = '0;
               next_events = (events_q != 8'hFF) ? events_q + 8'd1 : events_q;
            end
         end
         FAIL_ST: begin
            next_state = FAIL_ST;
         end
         default: begin
            next_state = RESET_PLL;
            next_cnt   = '0;
         end
      endcase

      // A relock request overrides whatever the state logic chose, except in FAIL
      if (bus.relock_req && state != FAIL_ST) begin
         next_state  = RESET_PLL;
         next_cnt    = '0;
         next_retry  = retry_q;
         next_events = events_q;
      end
   end

   // Outputs are decoded from the next state so they change on the same edge as the state
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state     <= RESET_PLL;
         cnt       <= '0;
         retry_q   <= '0;
         events_q  <= '0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state     <= next_state;
         cnt       <= next_cnt;
         retry_q   <= next_retry;
         events_q  <= next_events;
         pll_rst_q <= (next_state == RESET_PLL) || (next_state == FAIL_ST);
         sys_rst_q <= (next_state != RUN);
         ready_q   <= (next_state == RUN);
         fail_q    <= fail_q || (next_state == FAIL_ST);
      end
   end

   assign bus.pll_rst       = pll_rst_q;
   assign bus.sys_rst       = sys_rst_q;
   assign bus.ready         = ready_q;
   assign bus.fail          = fail_q;
   assign bus.retry_count   = retry_q;
   assign bus.relock_events = events_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with small parameters: a cycle-vector table for
// power-up / lock loss / retry, plus hand sequences for timeout-to-fail, glitch, relock and reset.
`timescale 1ns/1ps
module tb_pll_reset_ctrl;

   logic refclk;
   logic rst;
   int   check_count;
   int   fail_count;

   pll_reset_ctrl_if bus ();

   pll_reset_ctrl #(
      .RST_PULSE_CYCLES  (4),
      .LOCK_TIMEOUT      (20),
      .LOCK_STABLE_CYCLES(8),
      .MAX_RETRIES       (2),
      .CNT_W             (16)
   ) dut (
      .refclk(refclk),
      .rst   (rst),
      .bus   (bus.master)
   );

   typedef struct {
      int         cycles;
      logic       locked;
      logic       req;
      logic       exp_pll_rst;
      logic       exp_sys_rst;
      logic       exp_ready;
      logic       exp_fail;
      logic [2:0] exp_retry;
      logic [7:0] exp_events;
   } vec_t;

   vec_t vecs[15];

   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   // Hard stop in case a sequence never returns
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic stepCycles(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      check_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic e_pll_rst, input logic e_sys_rst,
                           input logic e_ready, input logic e_fail, input logic [2:0] e_retry,
                           input logic [7:0] e_events);
      checkOutput({tag, ".pll_rst"},       int'(bus.pll_rst),       int'(e_pll_rst));
      checkOutput({tag, ".sys_rst"},       int'(bus.sys_rst),       int'(e_sys_rst));
      checkOutput({tag, ".ready"},         int'(bus.ready),         int'(e_ready));
      checkOutput({tag, ".fail"},          int'(bus.fail),          int'(e_fail));
      checkOutput({tag, ".retry_count"},   int'(bus.retry_count),   int'(e_retry));
      checkOutput({tag, ".relock_events"}, int'(bus.relock_events), int'(e_events));
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.pll_locked = v.locked;
      bus.relock_req = v.req;
      stepCycles(v.cycles);
   endtask

   // Release happens 1 time unit after an edge, so edge counts start from the next posedge
   task automatic startFrom(input logic locked);
      rst            = 1'b1;
      bus.pll_locked = locked;
      bus.relock_req = 1'b0;
      stepCycles(2);
      rst = 1'b0;
   endtask

   initial begin
      check_count = 0;
      fail_count  = 0;
      rst            = 1'b1;
      bus.pll_locked = 1'b0;
      bus.relock_req = 1'b0;

      // Power-up, lock loss in RUN, then one timeout retry before re-lock
      vecs[0]  = '{3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
      vecs[1]  = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
      vecs[2]  = '{6,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
      vecs[3]  = '{10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
      vecs[4]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0};
      vecs[5]  = '{5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0};
      vecs[6]  = '{2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0};
      vecs[7]  = '{1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd1};
      vecs[8]  = '{3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd1};
      vecs[9]  = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd1};
      vecs[10] = '{19, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd1};
      vecs[11] = '{1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 8'd1};
      vecs[12] = '{4,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd1};
      vecs[13] = '{10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd1};
      vecs[14] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd1};

      stepCycles(2);
      checkAll("reset_state", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      rst = 1'b0;
      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i]);
         checkAll($sformatf("vec%0d", i), vecs[i].exp_pll_rst, vecs[i].exp_sys_rst,
                  vecs[i].exp_ready, vecs[i].exp_fail, vecs[i].exp_retry, vecs[i].exp_events);
      end

      $display("[TB] lock never arrives: retries exhaust into fail");
      startFrom(1'b0);
      stepCycles(4);  checkAll("to_e4",  1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      stepCycles(20); checkAll("to_e24", 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 8'd0);
      stepCycles(3);  checkAll("to_e27", 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 8'd0);
      stepCycles(1);  checkAll("to_e28", 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd0);
      stepCycles(20); checkAll("to_e48", 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0);
      stepCycles(4);  checkAll("to_e52", 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0);
      stepCycles(19); checkAll("to_e71", 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0);
      stepCycles(1);  checkAll("to_e72", 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 8'd0);
      bus.pll_locked = 1'b1;
      stepCycles(20); checkAll("fail_lock_ignored", 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 8'd0);
      bus.relock_req = 1'b1;
      stepCycles(1);
      bus.relock_req = 1'b0;
      stepCycles(5);  checkAll("fail_req_ignored", 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 8'd0);

      $display("[TB] lock glitch during the stability window");
      startFrom(1'b1);
      stepCycles(9);  checkAll("gl_e9", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      bus.pll_locked = 1'b0;
      stepCycles(3);
      bus.pll_locked = 1'b1;
      stepCycles(1);  checkAll("gl_e13", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      stepCycles(9);  checkAll("gl_e22", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      stepCycles(1);  checkAll("gl_e23", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0);

      $display("[TB] relock requests in RUN and WAIT_LOCK");
      startFrom(1'b1);
      stepCycles(13); checkAll("rq_run", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
      bus.pll_locked = 1'b0;
      stepCycles(3);  checkAll("rq_loss", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd1);
      bus.pll_locked = 1'b1;
      stepCycles(13); checkAll("rq_rerun", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd1);
      stepCycles(1);
      bus.relock_req = 1'b1;
      stepCycles(1);
      bus.relock_req = 1'b0;
      checkAll("rq_in_run", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd1);
      stepCycles(4);  checkAll("rq_wait", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd1);
      bus.relock_req = 1'b1;
      stepCycles(1);
      bus.relock_req = 1'b0;
      checkAll("rq_in_wait", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd1);
      stepCycles(4);  checkAll("rq_wait2", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd1);
      stepCycles(8);  checkAll("rq_b19", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd1);
      stepCycles(1);  checkAll("rq_b20", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd1);

      $display("[TB] repeated lock losses saturate the event counter");
      for (int i = 0; i < 300; i++) begin
         bus.pll_locked = 1'b0;
         stepCycles(3);
         bus.pll_locked = 1'b1;
         stepCycles(13);
         if (i == 0)   checkAll("sat_first", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd2);
         if (i == 252) checkOutput("sat_254", int'(bus.relock_events), 254);
      end
      checkAll("sat_final", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd255);

      $display("[TB] async reset between edges while waiting for lock");
      bus.pll_locked = 1'b0;
      bus.relock_req = 1'b1;
      stepCycles(1);
      bus.relock_req = 1'b0;
      stepCycles(6);
      checkAll("ar_wait", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd255);
      #3;
      rst = 1'b1;
      #1;
      checkAll("ar_async", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      stepCycles(2);
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
      $finish;
   end

endmodule
